// File: rtl/io_in_pkg.sv
// Shared constants and decode helpers for the memory-mapped input port bank.
// Optional debounce logic is selected by the IO_IN_DEBOUNCE_EN macro.
package io_in_pkg;

  localparam logic [5:0] IO_SEL_BASE  = 6'b110000;
  localparam int         IO_MAX_PORTS = 16;
  localparam int         IO_MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    SEL_NONE   = 2'd0,
    SEL_PORT   = 2'd1,
    SEL_STATUS = 2'd2
  } io_sel_kind_e;

  // The status word sits immediately after the last port register.
  function automatic logic [5:0] io_status_sel(input logic [5:0] base, input int nports);
    return base + 6'(nports);
  endfunction

endpackage

// File: rtl/io_in_debounce.sv
// One input port: 2-flop synchroniser, optional debounce (IO_IN_DEBOUNCE_EN),
// and the held stable value. chg_pulse is high in the cycle before stable updates.
module io_in_debounce
  import io_in_pkg::*;
#(
  parameter int WIDTH = 32
`ifdef IO_IN_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYCLES = 16
`endif
) (
  input  logic             io_clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] in_raw,
  output logic [WIDTH-1:0] stable_out,
  output logic             chg_pulse
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] stable_q, stable_d;

  always_comb begin
    sync1_d = in_raw;
    sync2_d = sync1_q;
  end

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
    end
  end

`ifdef IO_IN_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] samp_q, samp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  // The count only advances while sync2 holds a value different from stable.
  always_comb begin
    samp_d   = sync2_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    accept   = 1'b0;
    if ((sync2_q != samp_q) || (sync2_q == stable_q)) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      stable_d = sync2_q;
      accept   = 1'b1;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      samp_q <= '0;
      cnt_q  <= '0;
    end else begin
      samp_q <= samp_d;
      cnt_q  <= cnt_d;
    end
  end

  assign chg_pulse = accept;
`else
  assign stable_d  = sync2_q;
  assign chg_pulse = (sync2_q != stable_q);
`endif

  assign stable_out = stable_q;

endmodule

// File: rtl/io_input_bank.sv
// Memory-mapped bank of NPORTS synchronised input ports with sticky clear-on-read
// change status and summary IRQ. Debounce is included when IO_IN_DEBOUNCE_EN is defined.
module io_input_bank
  import io_in_pkg::*;
#(
  parameter int         NPORTS          = 4,
  parameter int         WIDTH           = 32,
  parameter int         DEBOUNCE_CYCLES = 16,
  parameter logic [5:0] SEL_BASE        = IO_SEL_BASE
) (
  input  logic                    io_clk,
  input  logic                    resetn,
  input  logic [31:0]             addr,
  input  logic                    rd_en,
  input  logic [NPORTS*WIDTH-1:0] in_port,
  output logic [31:0]             io_read_data,
  output logic                    chg_irq
);

  localparam logic [5:0] STATUS_SEL = io_status_sel(SEL_BASE, NPORTS);

  logic [WIDTH-1:0]  stable_w [NPORTS];
  logic [NPORTS-1:0] chg_pulse;
  logic [NPORTS-1:0] chg_q, chg_d;
  logic [5:0]        sel;
  io_sel_kind_e      sel_kind;
  logic [31:0]       port_data;
  logic              unused_addr;

  assign sel         = addr[7:2];
  assign unused_addr = ^{addr[31:8], addr[1:0]};

  generate
    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
      io_in_debounce #(
        .WIDTH(WIDTH)
`ifdef IO_IN_DEBOUNCE_EN
        , .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`endif
      ) u_deb (
        .io_clk    (io_clk),
        .resetn    (resetn),
        .in_raw    (in_port[gi*WIDTH +: WIDTH]),
        .stable_out(stable_w[gi]),
        .chg_pulse (chg_pulse[gi])
      );
    end
  endgenerate

  always_comb begin
    sel_kind  = SEL_NONE;
    port_data = 32'h0;
    for (int i = 0; i < NPORTS; i++) begin
      if (sel == SEL_BASE + 6'(i)) begin
        sel_kind  = SEL_PORT;
        port_data = 32'(stable_w[i]);
      end
    end
    if (sel == STATUS_SEL) begin
      sel_kind = SEL_STATUS;
    end
    case (sel_kind)
      SEL_PORT:   io_read_data = port_data;
      SEL_STATUS: io_read_data = 32'(chg_q);
      default:    io_read_data = 32'h0;
    endcase
  end

  // A status read clears what it returned; a same-edge event still sets its bit.
  always_comb begin
    if (rd_en && (sel_kind == SEL_STATUS)) begin
      chg_d = chg_pulse;
    end else begin
      chg_d = chg_q | chg_pulse;
    end
  end

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      chg_q <= '0;
    end else begin
      chg_q <= chg_d;
    end
  end

  assign chg_irq = |chg_q;

endmodule

// File: tb/tb_io_input_bank.sv
// Randomised and directed bench for io_input_bank against a history-based reference model.
module tb_io_input_bank;

  localparam int NP = 4;
  localparam int W  = 8;
  localparam int DB = 16;
`ifdef IO_IN_DEBOUNCE_EN
  localparam int DE = DB;
`else
  localparam int DE = 0;
`endif
  localparam int LAT  = 3 + DE;
  localparam int HL   = DE + 2;
  localparam int BASE = 'h30;
  localparam int STAT = BASE + NP;

  logic              io_clk  = 1'b0;
  logic              resetn  = 1'b0;
  logic [31:0]       addr    = 32'h0;
  logic              rd_en   = 1'b0;
  logic [NP*W-1:0]   in_port = '0;
  logic [31:0]       io_read_data;
  logic              chg_irq;
  logic              cmp_en  = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 io_clk = ~io_clk;

  io_input_bank #(
    .NPORTS         (NP),
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(DB),
    .SEL_BASE       (6'h30)
  ) dut (
    .io_clk      (io_clk),
    .resetn      (resetn),
    .addr        (addr),
    .rd_en       (rd_en),
    .in_port     (in_port),
    .io_read_data(io_read_data),
    .chg_irq     (chg_irq)
  );

  // Reference model: hist[p][j] is the raw sample taken j+1 edges ago.
  // A port accepts value v when the last DE+1 synchronised samples all equal v
  // and v differs from the held value.
  logic [W-1:0]  hist     [NP][HL];
  logic [W-1:0]  m_stable [NP];
  logic [NP-1:0] m_chg, m_ev, m_clr;
  logic [W-1:0]  m_v;
  logic          m_ok;

  always @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      for (int p = 0; p < NP; p++) begin
        m_stable[p] = '0;
        for (int j = 0; j < HL; j++) hist[p][j] = '0;
      end
      m_chg = '0;
    end else begin
      m_ev = '0;
      for (int p = 0; p < NP; p++) begin
        m_v  = hist[p][1];
        m_ok = (m_v != m_stable[p]);
        for (int j = 1; j < HL; j++) if (hist[p][j] != m_v) m_ok = 1'b0;
        if (m_ok) begin
          m_stable[p] = m_v;
          m_ev[p]     = 1'b1;
        end
        for (int j = HL - 1; j > 0; j--) hist[p][j] = hist[p][j-1];
        hist[p][0] = in_port[p*W +: W];
      end
      m_clr = (rd_en && (int'(addr[7:2]) == STAT)) ? m_chg : '0;
      m_chg = (m_chg & ~m_clr) | m_ev;
    end
  end

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    int s;
    s = int'(a[7:2]);
    if (s >= BASE && s < BASE + NP) return 32'(m_stable[s-BASE]);
    if (s == STAT) return 32'(m_chg);
    return 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge io_clk) begin
    if (cmp_en) begin
      check("model_read", io_read_data, exp_read(addr));
      check("model_irq", {31'b0, chg_irq}, {31'b0, |m_chg});
    end
  end

  task automatic tick();
    @(posedge io_clk);
    #1;
  endtask

  task automatic set_sel(input int s);
    addr      = $urandom();
    addr[7:2] = 6'(s);
  endtask

  task automatic set_port(input int p, input logic [W-1:0] v);
    in_port[p*W +: W] = v;
  endtask

  task automatic clear_status();
    set_sel(STAT);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    // Reset with all inputs high; nothing may appear before LAT edges after release.
    in_port = '1;
    set_sel(STAT);
    tick();
    cmp_en = 1'b1;
    repeat (2) tick();
    resetn = 1'b1;
    for (int e = 1; e <= LAT; e++) begin
      @(posedge io_clk);
      @(negedge io_clk);
      if (e < LAT) begin
        check("reset_status_quiet", io_read_data, 32'h0);
        check("reset_irq_quiet", {31'b0, chg_irq}, 32'h0);
      end else begin
        check("reset_status_set", io_read_data, 32'hF);
        check("reset_irq_set", {31'b0, chg_irq}, 32'h1);
      end
    end
    tick();
    set_sel(BASE + 3);
    @(negedge io_clk);
    check("port3_ones", io_read_data, 32'h0000_00FF);

    tick();
    set_sel(STAT);
    rd_en = 1'b1;
    @(negedge io_clk);
    check("clear_read", io_read_data, 32'hF);
    tick();
    rd_en = 1'b0;
    @(negedge io_clk);
    check("clear_after", io_read_data, 32'h0);
    check("clear_irq", {31'b0, chg_irq}, 32'h0);

    // Return all ports to zero and discard the resulting events.
    tick();
    in_port = '0;
    repeat (LAT + 2) tick();
    clear_status();

    // Step on port 1.
    set_sel(BASE + 1);
    set_port(1, 8'h5A);
    for (int e = 1; e <= LAT; e++) begin
      @(posedge io_clk);
      @(negedge io_clk);
      check((e < LAT) ? "step_before" : "step_after", io_read_data, (e < LAT) ? 32'h0 : 32'h5A);
    end
    tick();
    set_sel(STAT);
    @(negedge io_clk);
    check("step_status", io_read_data, 32'h2);
    check("step_irq", {31'b0, chg_irq}, 32'h1);
    tick();
    clear_status();

    // Ten-cycle glitch on port 0.
    set_port(0, 8'h01);
    repeat (10) tick();
    set_port(0, 8'h00);
    set_sel(BASE);
`ifdef IO_IN_DEBOUNCE_EN
    repeat (DB + 6) begin
      @(negedge io_clk);
      check("glitch_port0", io_read_data, 32'h0);
      tick();
    end
    set_sel(STAT);
    @(negedge io_clk);
    check("glitch_status", io_read_data, 32'h0);
`else
    repeat (LAT + 2) tick();
`endif
    tick();
    clear_status();

    // Port 2 event lands on the same edge as a status clear.
    set_port(1, 8'hA5);
    tick();
    set_port(2, 8'h3C);
    repeat (LAT - 1) tick();
    set_sel(STAT);
    rd_en = 1'b1;
    @(negedge io_clk);
    check("race_read", io_read_data, 32'h2);
    tick();
    rd_en = 1'b0;
    @(negedge io_clk);
    check("race_status", io_read_data, 32'h4);
    check("race_irq", {31'b0, chg_irq}, 32'h1);

    // Decode corners with random upper/lower address bits.
    tick();
    set_sel(BASE + 2);
    @(negedge io_clk);
    check("dec_port2", io_read_data, 32'h3C);
    tick();
    set_sel(BASE - 1);
    @(negedge io_clk);
    check("dec_below", io_read_data, 32'h0);
    tick();
    set_sel(STAT + 1);
    @(negedge io_clk);
    check("dec_above", io_read_data, 32'h0);

    // Reset in the middle of a count; the count restarts after release.
    tick();
    set_port(3, 8'h77);
    repeat (5) tick();
    resetn = 1'b0;
    set_sel(BASE + 3);
    tick();
    resetn = 1'b1;
    for (int e = 1; e <= LAT; e++) begin
      @(posedge io_clk);
      @(negedge io_clk);
      check((e < LAT) ? "midreset_before" : "midreset_after", io_read_data, (e < LAT) ? 32'h0 : 32'h77);
    end

    // Random traffic; the compare process checks every cycle.
    tick();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 4) begin
        set_port(int'($urandom_range(0, NP - 1)), W'($urandom()));
      end
      set_sel(int'($urandom_range(BASE - 2, STAT + 2)));
      rd_en  = ($urandom_range(0, 3) == 0);
      resetn = ($urandom_range(0, 999) != 0);
      tick();
    end
    resetn = 1'b1;
    rd_en  = 1'b0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_input_bank.md
# io_input_bank

Parametrised memory-mapped input port bank for the single-cycle CPU's I/O space: the next generation of the two-port latch-and-mux input register. It synchronises NPORTS external input ports into the `io_clk` domain, optionally debounces them, and holds a stable value per port. It records per-port change events in a sticky, clear-on-read status register with an interrupt-style summary output. The CPU reads every port and the status word through the same `addr[7:2]` word-select decode used by the rest of the I/O space.

## Interface
- NPORTS, 4: number of input ports, 1..16
- WIDTH, 32: bits per port, 1..32; narrower ports zero-extend on read
- DEBOUNCE_CYCLES, 16: consecutive stable cycles before a new value is accepted, ≥2; unused when debounce compiled out
- SEL_BASE, 6'b110000: `addr[7:2]` value of port 0
- io_clk  in  1  I/O clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- addr  in  32  CPU byte address; only `addr[7:2]` decoded
- rd_en  in  1  CPU read strobe for this cycle; qualifies clear-on-read
- in_port  in  NPORTS*WIDTH  raw external inputs, port i at `[i*WIDTH +: WIDTH]`
- io_read_data  out  32  read data, combinational from registers
- chg_irq  out  1  OR of all sticky change bits

## Operation
- Per port: `sync1 <= in`, `sync2 <= sync1`. This is a 2-flop synchroniser, applied to all bits.
- With debounce, per port:
  - `samp <= sync2` every cycle, plus counter `cnt` of width `$clog2(DEBOUNCE_CYCLES)`.
  - If `sync2 != samp` or `sync2 == stable`, then `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`, then `stable <= sync2`, `chg[i] <= 1`, `cnt <= 0`.
  - Else `cnt <= cnt+1`.
- Without debounce: `stable <= sync2`; `chg[i] <= 1` when `sync2 != stable`.
- Read decode on `sel = addr[7:2]`:
  - `SEL_BASE+i` (i < NPORTS): `{zeros, stable_i}`.
  - `SEL_BASE+NPORTS`: `{zeros, chg[NPORTS-1:0]}`.
  - Any other value: 32'h0. Never X, never latched.
- Clear-on-read: when `rd_en=1` and `sel==SEL_BASE+NPORTS`, the chg bits returned are cleared at the next edge.
- A change event on the same edge as the clear wins for that bit: the bit stays 1.
- Reads of port registers have no side effects.
- `chg_irq = |chg`.

## Timing
- Reset (`resetn=0`, asynchronous):
  - All sync, samp, stable, cnt and chg registers go to 0.
  - `io_read_data` is 0 for every address; `chg_irq` = 0.
- Reset deasserted mid-debounce: the count restarts from 0. Release is treated as synchronous to `io_clk` by the system.
- Latency, for an input change stable before edge 1:
  - Debounce on: `stable` and `chg` update at edge 3+DEBOUNCE_CYCLES (edge 19 at default).
  - Debounce off: update at edge 3.
- Any change of `sync2` during the count restarts it. A glitch shorter than DEBOUNCE_CYCLES never reaches `stable`.
- Multi-bit port: every bit must hold the same value for the full window.
- `io_read_data` settles combinationally within the same cycle `addr` is presented.

## Configuration
- `IO_IN_DEBOUNCE_EN`
  - Defined: per-port debounce counter and samp register as above.
  - Undefined: the counter logic is absent and DEBOUNCE_CYCLES is ignored. `stable` follows `sync2` with one register stage; status and IRQ behaviour are otherwise unchanged.

## Structure
- Package `io_in_pkg`:
  - `IO_SEL_BASE` (6'b110000).
  - `IO_MAX_PORTS` (16), `IO_MAX_WIDTH` (32).
  - Status-word offset constant (NPORTS relative to base).
- Sub-module `io_in_debounce`, generated once per port. It contains sync1/sync2/samp/cnt/stable and emits a one-cycle `chg_pulse`.
- The top holds the chg register, the clear logic and the read mux.

## Test plan
- Reset: `resetn=0` with `in_port` all-ones, then release.
  - Required: all reads 0 and `chg_irq=0` until edge 3+DEBOUNCE_CYCLES after release.
- Debounced step: port 1 changes 0→32'h5A at edge 0, held steady, default params.
  - Required: `sel=6'h31` reads 0 through edge 18 and 32'h5A after edge 19; `chg=4'b0010`; `chg_irq=1`.
- Glitch: port 0 pulses to 32'h1 for 10 cycles, then back to 0.
  - Required: port 0 read stays 0; `chg` stays 0.
- Clear-on-read: with `chg=4'b0011`, read `sel=6'h34` with `rd_en=1`.
  - Required: returns 32'h3; next cycle `chg=0`, `chg_irq=0`.
- Same-edge race: port 2 event lands on the same edge as the status clear.
  - Required: `chg=4'b0100` afterwards.
- Decode, with WIDTH=8, NPORTS=2:
  - Read `sel=6'h30` with port 0 = 8'hFF → 32'h000000FF.
  - `sel=6'h2F` → 32'h0; `sel=6'h33` → 32'h0.
  - Repeat with `IO_IN_DEBOUNCE_EN` undefined: the 0→8'hFF step is visible after edge 3.
